// File: rtl/slc3_arb_pkg.sv
// Shared types and constants for the SLC-3 memory arbiter.
//   arb_state_t : arbiter/sequencer FSM states
//   OWN_CPU/DBG : encoding of the owner/grant bit
//   LAT_CNT_W   : width of the read-latency counter (RD_LAT up to 7)
package slc3_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam int unsigned LAT_CNT_W = 3;

endpackage

// File: rtl/slc3_rr_pick.sv
// Combinational 2-way grant picker.
//   req[1:0] : requests, bit 0 = CPU, bit 1 = DBG
//   last     : previous grant (OWN_CPU / OWN_DBG)
//   prio     : 1 = CPU wins every tie, 0 = round-robin on ties
//   gnt      : selected requester; OWN_CPU when nothing is requested
module slc3_rr_pick
  import slc3_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio,
  output logic       gnt
);

  always_comb begin
    gnt = OWN_CPU;
    if (req == 2'b11) begin
      // Tie: the requester not served last wins, unless CPU priority is on.
      gnt = prio ? OWN_CPU : ~last;
    end else if (req[1]) begin
      gnt = OWN_DBG;
    end
  end

endmodule

// File: rtl/slc3_mem_arbiter.sv
// Arbiter and access sequencer sharing the single-port SLC-3 memory between
// the CPU (MAR/MDR) and the debug/loader port. One transaction in flight:
// IDLE (grant + latch) -> ISSUE (mem_ce strobe) -> [WAIT (RD_LAT cycles)] -> DONE (ready).
//
// Ports:
//   Clk, Reset                 : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      : CPU request side; cpu_rdata/cpu_ready back
//   dbg_req/we/addr/wdata      : debug request side; dbg_rdata/dbg_ready back
//   mem_ce/we/addr/wdata       : registered memory strobe/command
//   mem_rdata                  : memory read data, valid RD_LAT cycles after mem_ce
//   busy                       : FSM not in IDLE
//   owner                      : current or last grant (0 = CPU, 1 = DBG)
//
// Build option: define SLC3_ARB_CPU_PRIO_EN for fixed CPU priority on ties
// (debug can starve); otherwise ties alternate round-robin.
module slc3_mem_arbiter
  import slc3_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ready,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

`ifdef SLC3_ARB_CPU_PRIO_EN
  localparam logic PrioMode = 1'b1;
`else
  localparam logic PrioMode = 1'b0;
`endif

  // WAIT spans RD_LAT cycles; the counter ends on RD_LAT-1.
  localparam logic [LAT_CNT_W-1:0] LastCnt = LAT_CNT_W'(RD_LAT - 1);

  arb_state_t          st_q, st_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                mem_ce_q, mem_ce_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic                dbg_ready_q, dbg_ready_d;
  logic                owner_q, owner_d;
  logic                gnt;

  slc3_rr_pick u_pick (
    .req  ({dbg_req, cpu_req}),
    .last (owner_q),
    .prio (PrioMode),
    .gnt  (gnt)
  );

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    mem_ce_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_ready_d = 1'b0;
    dbg_ready_d = 1'b0;
    owner_d     = owner_q;

    unique case (st_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          owner_d     = gnt;
          mem_we_d    = (gnt == OWN_DBG) ? dbg_we    : cpu_we;
          mem_addr_d  = (gnt == OWN_DBG) ? dbg_addr  : cpu_addr;
          mem_wdata_d = (gnt == OWN_DBG) ? dbg_wdata : cpu_wdata;
          mem_ce_d    = 1'b1;
          st_d        = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (mem_we_q) begin
          st_d = DONE;
          if (owner_q == OWN_DBG) dbg_ready_d = 1'b1;
          else                    cpu_ready_d = 1'b1;
        end else begin
          st_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LastCnt) begin
          st_d = DONE;
          if (owner_q == OWN_DBG) begin
            dbg_rdata_d = mem_rdata;
            dbg_ready_d = 1'b1;
          end else begin
            cpu_rdata_d = mem_rdata;
            cpu_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        st_d = IDLE;
      end
      default: begin
        st_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st_q        <= IDLE;
      cnt_q       <= '0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dbg_ready_q <= 1'b0;
      owner_q     <= OWN_DBG;  // so the CPU wins the first tie
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      dbg_ready_q <= dbg_ready_d;
      owner_q     <= owner_d;
    end
  end

  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign dbg_ready = dbg_ready_q;
  assign owner     = owner_q;
  assign busy      = (st_q != IDLE);

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Directed bench for slc3_mem_arbiter with RD_LAT = 2 and a small memory model.
module tb_slc3_mem_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned RD_LAT = 2;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              cpu_req, cpu_we, dbg_req, dbg_we;
  logic [ADDR_W-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata;
  logic [DATA_W-1:0] mem_rdata = 16'hDEAD;
  logic              cpu_ready, dbg_ready, mem_ce, mem_we, busy, owner;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  slc3_mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .dbg_ready (dbg_ready),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  // Memory model: read data valid only during cycle A+2, 16'hDEAD otherwise.
  logic [15:0] mem [256];
  logic [15:0] rd_p1 = 16'h0;
  logic        v1 = 1'b0;
  always @(posedge Clk) begin
    if (mem_ce && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    v1        <= mem_ce && !mem_we;
    rd_p1     <= mem[mem_addr[7:0]];
    mem_rdata <= v1 ? rd_p1 : 16'hDEAD;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_own;
    Reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    tick(); tick();
    Reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_ce", mem_ce, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_dbg_ready", dbg_ready, 0);
    chk("rst_owner", owner, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);

    // CPU write alone
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'h1234;
    tick();  // T+1
    chk("wr_ce", mem_ce, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 16'h0010);
    chk("wr_wdata", mem_wdata, 16'h1234);
    chk("wr_owner", owner, 0);
    chk("wr_busy", busy, 1);
    chk("wr_ready_early", cpu_ready, 0);
    tick();  // T+2
    chk("wr_ready", cpu_ready, 1);
    chk("wr_dbg_ready", dbg_ready, 0);
    chk("wr_ce_off", mem_ce, 0);
    cpu_req = 0;
    tick();  // T+3
    chk("wr_ready_pulse", cpu_ready, 0);
    chk("wr_idle", busy, 0);

    // CPU read alone
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    tick();  // T+1
    chk("rd_ce", mem_ce, 1);
    chk("rd_we", mem_we, 0);
    tick();  // T+2
    chk("rd_ce_off", mem_ce, 0);
    chk("rd_ready_t2", cpu_ready, 0);
    tick();  // T+3
    chk("rd_ready_t3", cpu_ready, 0);
    tick();  // T+4
    chk("rd_ready", cpu_ready, 1);
    chk("rd_cpu_rdata", cpu_rdata, 16'h1234);
    chk("rd_dbg_rdata", dbg_rdata, 16'h0000);
    cpu_req = 0;
    tick();
    chk("rd_ready_pulse", cpu_ready, 0);
    chk("rd_idle", busy, 0);

    // Simultaneous requests just after reset
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("sim_rst_owner", owner, 1);
    chk("sim_rst_cpu_rdata", cpu_rdata, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0020; dbg_wdata = 16'hBEEF;
    tick();  // T+1
    chk("sim_owner_cpu", owner, 0);
    chk("sim_addr_cpu", mem_addr, 16'h0010);
    tick(); tick(); tick();  // T+4
    chk("sim_cpu_ready", cpu_ready, 1);
    chk("sim_cpu_rdata", cpu_rdata, 16'h1234);
    chk("sim_dbg_ready_early", dbg_ready, 0);
    cpu_req = 0;
    tick();  // T+5
    chk("sim_idle", busy, 0);
    tick();  // T+6
    chk("sim_dbg_ce", mem_ce, 1);
    chk("sim_dbg_addr", mem_addr, 16'h0020);
    chk("sim_dbg_wdata", mem_wdata, 16'hBEEF);
    chk("sim_dbg_owner", owner, 1);
    tick();  // T+7
    chk("sim_dbg_ready", dbg_ready, 1);
    chk("sim_cpu_ready_quiet", cpu_ready, 0);
    dbg_req = 0;
    tick();

    // Round-robin fairness with both requesters held
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 16'h1111;
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0040; dbg_wdata = 16'h2222;
    for (int i = 0; i < 6; i++) begin
`ifdef SLC3_ARB_CPU_PRIO_EN
      exp_own = 1'b0;
`else
      exp_own = 1'(i % 2);
`endif
      tick();  // ISSUE
      chk($sformatf("rr%0d_owner", i), owner, exp_own);
      chk($sformatf("rr%0d_addr", i), mem_addr, exp_own ? 16'h0040 : 16'h0030);
      tick();  // DONE
      chk($sformatf("rr%0d_ready", i), {cpu_ready, dbg_ready}, exp_own ? 2'b01 : 2'b10);
      if (i == 5) begin
        cpu_req = 0; dbg_req = 0;
      end
      tick();  // IDLE
    end
    chk("rr_idle", busy, 0);

    // Reset in the middle of a read
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030;
    tick();  // ISSUE
    tick();  // WAIT
    chk("mid_busy_wait", busy, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_ce", mem_ce, 0);
    chk("mid_ready", cpu_ready, 0);
    chk("mid_cpu_rdata", cpu_rdata, 0);
    chk("mid_owner", owner, 1);
    tick();  // T+1 of the fresh read
    chk("mid_ready_none", cpu_ready, 0);
    chk("mid_new_ce", mem_ce, 1);
    tick(); tick(); tick();  // T+4
    chk("mid_new_ready", cpu_ready, 1);
    chk("mid_new_rdata", cpu_rdata, 16'h1111);
    cpu_req = 0;
    tick();

    // Back-to-back debug writes
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0050; dbg_wdata = 16'hA0A0;
    for (int i = 0; i < 3; i++) begin
      tick();  // ISSUE
      chk($sformatf("b2b%0d_ce", i), mem_ce, 1);
      chk($sformatf("b2b%0d_addr", i), mem_addr, 16'h0050 + 16'(i));
      chk($sformatf("b2b%0d_ready_early", i), dbg_ready, 0);
      tick();  // DONE
      chk($sformatf("b2b%0d_ce_width", i), mem_ce, 0);
      chk($sformatf("b2b%0d_ready", i), dbg_ready, 1);
      dbg_addr = 16'h0051 + 16'(i);
      dbg_wdata = 16'hA0A1 + 16'(i);
      if (i == 2) dbg_req = 0;
      tick();  // IDLE
      chk($sformatf("b2b%0d_gap", i), {dbg_ready, mem_ce}, 2'b00);
    end

    // Debug readback of the middle write; CPU result untouched
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0051;
    tick(); tick(); tick(); tick();  // T+4
    chk("dbg_rd_ready", dbg_ready, 1);
    chk("dbg_rd_rdata", dbg_rdata, 16'hA0A1);
    chk("dbg_rd_cpu_rdata", cpu_rdata, 16'h1111);
    dbg_req = 0;
    tick();
    chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slc3_mem_arbiter.md
Name: slc3_mem_arbiter

Overview:
- Shares the single-port on-chip SLC-3 program/data memory between two requesters: the CPU memory interface (MAR/MDR path) and the debug/loader port (switch-driven memory inspection and preload).
- Registered arbiter plus access sequencer: one transaction in flight, fixed read latency, one-cycle ready pulse back to the winning requester.
- Sits between the SLC-3 datapath/state controller and the memory instance inside the top level.

Parameters:
- ADDR_W, 16, address width of both requesters and memory.
- DATA_W, 16, data width.
- RD_LAT, 2, memory read latency in cycles from the mem_ce cycle to valid mem_rdata; legal range 1..7.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU request; held high until cpu_ready is seen.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address (MAR).
- cpu_wdata  in  DATA_W  CPU write data (MDR).
- cpu_rdata  out  DATA_W  last CPU read result, registered.
- cpu_ready  out  1  one-cycle completion pulse to the CPU.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ready: same widths and semantics as the cpu_* ports, for the debug port.
- mem_ce  out  1  memory access strobe, registered.
- mem_we  out  1  memory write enable, registered; only meaningful while mem_ce is high.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever the FSM is not in IDLE.
- owner  out  1  current or last grant (0 = CPU, 1 = DBG).

Behaviour:
- Reset values:
  - FSM = IDLE.
  - mem_ce, mem_we, cpu_ready, dbg_ready, busy = 0.
  - mem_addr, mem_wdata, cpu_rdata, dbg_rdata = 0.
  - owner = 1 (DBG last served, so the CPU wins the first tie).
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any request is high, select a winner and latch its we, addr and wdata into the mem_* registers.
  - Set owner to the winner and go to ISSUE.
- ISSUE (exactly one cycle, called cycle A):
  - mem_ce = 1 and mem_we = latched we.
  - A write goes to DONE.
  - A read goes to WAIT.
- WAIT:
  - mem_ce = 0; a counter runs RD_LAT-1 cycles.
  - mem_rdata is sampled at the end of cycle A+RD_LAT into the owner's rdata register, then the FSM goes to DONE.
  - If RD_LAT = 1, WAIT lasts one cycle.
- DONE (one cycle): the owner's ready = 1, the other ready = 0. The FSM then returns to IDLE.
- Latency, with the request first seen in IDLE at cycle T:
  - Write: mem_ce at T+1, ready at T+2.
  - Read: mem_ce at T+1, ready at T+2+RD_LAT.
  - Minimum spacing between two grants is 3 cycles for writes and 3+RD_LAT cycles for reads.
- Handshake rules:
  - The requester drops req in the cycle after it sees ready.
  - Because DONE is followed by IDLE, a req still high during DONE is not re-granted until the IDLE cycle.
  - A requester that keeps req high through IDLE starts a new transaction (intended for back-to-back accesses).
- Arbitration (round-robin, 2-way):
  - A single request is granted immediately.
  - On a tie, the requester not equal to owner wins.
  - Request and address changes outside IDLE are ignored; only the latched values are used.
- rdata registers change only on completion of a read owned by that port. Writes and the other port's reads leave them unchanged.
- Reset mid-transaction: the next edge forces IDLE with the reset values above. The aborted access produces no ready pulse. A write already strobed in ISSUE may have completed in memory.
- busy = (state != IDLE).

Optional Feature:
- Macro: SLC3_ARB_CPU_PRIO_EN.
- Defined: fixed priority; the CPU wins every tie regardless of owner. The debug port can starve while the CPU is streaming.
- Undefined: round-robin as above.

Decomposition:
- Package slc3_arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT, DONE}.
  - Owner constants OWN_CPU = 1'b0 and OWN_DBG = 1'b1.
  - Latency counter width constant, 3 bits.
- One sub-module, slc3_rr_pick: combinational 2-way picker with inputs req[1:0], last and a prio-mode input; output gnt. It carries the macro-selected policy and is unit-testable on its own.

Test Plan (RD_LAT = 2):
- CPU write alone: cpu_req=1, we=1, addr=16'h0010, wdata=16'h1234 at T -> mem_ce=1, mem_we=1, mem_addr=16'h0010, mem_wdata=16'h1234 at T+1; cpu_ready=1 at T+2 only; dbg_ready stays 0.
- CPU read alone: memory returns 16'h1234 at A+2 -> cpu_rdata=16'h1234 and cpu_ready=1 at T+4; dbg_rdata unchanged at 16'h0000.
- Simultaneous requests just after reset: CPU read of 16'h0010 and DBG write of 16'h0020 with 16'hBEEF, both held -> CPU granted first (owner=0, cpu_ready at T+4); DBG ISSUE at T+6 with mem_addr=16'h0020; dbg_ready at T+7; owner=1.
- Round-robin fairness: both requesters keep req high for 6 transactions -> grants alternate CPU, DBG, CPU, DBG, CPU, DBG. With SLC3_ARB_CPU_PRIO_EN defined -> all 6 grants go to the CPU.
- Reset mid-read: assert Reset during WAIT -> next cycle busy=0, mem_ce=0, no ready pulse, cpu_rdata=16'h0000; a fresh request after reset completes normally.
- Back-to-back writes: DBG req held for 3 writes -> ready pulses 3 cycles apart; each mem_ce is exactly one cycle wide.
